// File: rtl/lane_map_pkg.sv
// Shared types and sizing helpers for the functional-lane mapper and its selector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lane_map_pkg;

  // Run sequencing: wait, gather samples, evaluate, hold result.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Width of the sample counter and timeout timer.
  // Both share one width so a single comparator style serves both.
  function automatic int cnt_width(input int num_samples, input int timeout_cycles);
    int max_val;
    max_val = (num_samples > timeout_cycles) ? num_samples : timeout_cycles;
    return $clog2(max_val + 1);
  endfunction

  // Lanes per group. Group g owns lanes [g*LPG +: LPG].
  function automatic int lanes_per_group(input int num_lanes, input int num_groups);
    return num_lanes / num_groups;
  endfunction

endpackage

// File: rtl/lane_group_selector.sv
// Combinational lane-group selector: accumulated pass vector -> enabled-group mask.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the caller decides when the result is sampled.
module lane_group_selector
  import lane_map_pkg::*;
#(
  parameter int NUM_LANES  = 16,
  parameter int NUM_GROUPS = 2
) (
  input  logic [NUM_LANES-1:0]  i_acc,
  output logic [NUM_GROUPS-1:0] o_mask,
  output logic                  o_degraded
);

  localparam int LPG = lanes_per_group(NUM_LANES, NUM_GROUPS);

  logic [NUM_GROUPS-1:0] w_group_pass;

  // A group is usable only when every one of its lanes passed every sample.
  genvar g;
  generate
    for (g = 0; g < NUM_GROUPS; g++) begin : g_pass
      assign w_group_pass[g] = &i_acc[g*LPG +: LPG];
    end
  endgenerate

  // Full width if every group is clean, otherwise the highest clean group alone.
  always_comb begin
    o_mask = '0;
    if (&w_group_pass) begin
      o_mask = '1;
    end else begin
      // Ascending scan: the last hit is the highest-indexed passing group.
      for (int i = 0; i < NUM_GROUPS; i++) begin
        if (w_group_pass[i]) begin
          o_mask    = '0;
          o_mask[i] = 1'b1;
        end
      end
    end
  end

  assign o_degraded = (o_mask != {NUM_GROUPS{1'b1}});

endmodule

// File: rtl/functional_lane_mapper.sv
// Lane-degrade decision for functional-lane setup; optional LANE_MAP_REVERSAL_EN adds i_lane_reversal.
// Latency: i_start -> o_done in NUM_SAMPLES+2 cycles minimum; timeout after TIMEOUT_CYCLES in COLLECT.
// Backpressure: none; i_start while busy and i_result_valid outside COLLECT are dropped.
module functional_lane_mapper
  import lane_map_pkg::*;
#(
  parameter int NUM_LANES      = 16,
  parameter int NUM_GROUPS     = 2,
  parameter int NUM_SAMPLES    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_result_valid,
  input  logic [NUM_LANES-1:0]  i_result,
`ifdef LANE_MAP_REVERSAL_EN
  input  logic                  i_lane_reversal,
`endif
  output logic                  o_busy,
  output logic [NUM_GROUPS-1:0] o_functional_groups,
  output logic                  o_degraded,
  output logic                  o_timeout,
  output logic                  o_done
);

  localparam int              CW          = cnt_width(NUM_SAMPLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   LAST_SAMPLE = CW'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0]   LAST_TICK   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE     = CW'(1);

  state_t                r_state;
  state_t                w_state_nxt;

  logic [NUM_LANES-1:0]  w_sample;
  logic [NUM_LANES-1:0]  r_acc;
  logic [CW-1:0]         r_sample_cnt;
  logic [CW-1:0]         r_timer;

  logic                  w_last_sample;
  logic                  w_expire;

  logic [NUM_GROUPS-1:0] w_mask;
  logic                  w_mask_degraded;

  logic [NUM_GROUPS-1:0] r_groups;
  logic                  r_degraded;
  logic                  r_timeout;

  // ---------------------------------------------------------------------------
  // Sample conditioning: optional lane-order reversal ahead of the accumulator.
  // Reversing the sample (rather than the mask) means the group mask comes out
  // already expressed in the reversed lane order.
  // ---------------------------------------------------------------------------
`ifdef LANE_MAP_REVERSAL_EN
  logic [NUM_LANES-1:0] w_reversed;

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_rev
      assign w_reversed[l] = i_result[NUM_LANES-1-l];
    end
  endgenerate

  assign w_sample = i_lane_reversal ? w_reversed : i_result;
`else
  assign w_sample = i_result;
`endif

  // The final sample beats a simultaneous timer expiry.
  assign w_last_sample = i_result_valid && (r_sample_cnt == LAST_SAMPLE);
  assign w_expire      = (r_timer == LAST_TICK);

  // ---------------------------------------------------------------------------
  // Group evaluation on the accumulated history.
  // ---------------------------------------------------------------------------
  lane_group_selector #(
    .NUM_LANES  (NUM_LANES),
    .NUM_GROUPS (NUM_GROUPS)
  ) u_selector (
    .i_acc      (r_acc),
    .o_mask     (w_mask),
    .o_degraded (w_mask_degraded)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DECIDE is a single evaluation cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = COLLECT;
      end
      COLLECT: begin
        if (w_last_sample) begin
          w_state_nxt = DECIDE;
        end else if (w_expire) begin
          w_state_nxt = DONE;
        end
      end
      DECIDE: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        if (i_start) w_state_nxt = COLLECT;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Accumulator, counters and result registers. The previous mask is kept
  // through a new run so downstream sees a stable lane map until the decision.
  always_ff @(posedge CLK) begin
    if (rst) begin
      r_acc        <= '1;
      r_sample_cnt <= '0;
      r_timer      <= '0;
      r_groups     <= '1;
      r_degraded   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_acc        <= '1;
            r_sample_cnt <= '0;
            r_timer      <= '0;
            r_degraded   <= 1'b0;
            r_timeout    <= 1'b0;
          end
        end
        COLLECT: begin
          r_timer <= r_timer + CNT_ONE;
          if (i_result_valid) begin
            r_acc        <= r_acc & w_sample;
            r_sample_cnt <= r_sample_cnt + CNT_ONE;
          end
          if (!w_last_sample && w_expire) begin
            r_groups   <= '0;
            r_degraded <= 1'b1;
            r_timeout  <= 1'b1;
          end
        end
        DECIDE: begin
          r_groups   <= w_mask;
          r_degraded <= w_mask_degraded;
        end
        default: begin
          r_timer <= r_timer;
        end
      endcase
    end
  end

  assign o_busy              = (r_state == COLLECT) || (r_state == DECIDE);
  assign o_done              = (r_state == DONE);
  assign o_functional_groups = r_groups;
  assign o_degraded          = r_degraded;
  assign o_timeout           = r_timeout;

endmodule

// File: tb/tb_functional_lane_mapper.sv
// Directed bench: default, 4-group and short-timeout instances share one stimulus stream.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_functional_lane_mapper;

  logic        CLK = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_result_valid;
  logic [15:0] i_result;
  logic        i_lane_reversal;

  logic       a_busy, a_deg, a_to, a_done;
  logic [1:0] a_groups;
  logic       b_busy, b_deg, b_to, b_done;
  logic [3:0] b_groups;
  logic       c_busy, c_deg, c_to, c_done;
  logic [1:0] c_groups;

  int passed = 0;
  int total  = 0;

  always #5 CLK = ~CLK;

  functional_lane_mapper dut_a (
    .CLK (CLK), .rst (rst), .i_start (i_start),
    .i_result_valid (i_result_valid), .i_result (i_result),
`ifdef LANE_MAP_REVERSAL_EN
    .i_lane_reversal (i_lane_reversal),
`endif
    .o_busy (a_busy), .o_functional_groups (a_groups),
    .o_degraded (a_deg), .o_timeout (a_to), .o_done (a_done)
  );

  functional_lane_mapper #(.NUM_GROUPS(4)) dut_b (
    .CLK (CLK), .rst (rst), .i_start (i_start),
    .i_result_valid (i_result_valid), .i_result (i_result),
`ifdef LANE_MAP_REVERSAL_EN
    .i_lane_reversal (i_lane_reversal),
`endif
    .o_busy (b_busy), .o_functional_groups (b_groups),
    .o_degraded (b_deg), .o_timeout (b_to), .o_done (b_done)
  );

  functional_lane_mapper #(.TIMEOUT_CYCLES(8)) dut_c (
    .CLK (CLK), .rst (rst), .i_start (i_start),
    .i_result_valid (i_result_valid), .i_result (i_result),
`ifdef LANE_MAP_REVERSAL_EN
    .i_lane_reversal (i_lane_reversal),
`endif
    .o_busy (c_busy), .o_functional_groups (c_groups),
    .o_degraded (c_deg), .o_timeout (c_to), .o_done (c_done)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    i_result_valid = 1'b1;
    i_result       = d;
    step();
    i_result_valid = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    i_start         = 1'b0;
    i_result_valid  = 1'b0;
    i_result        = 16'h0000;
    i_lane_reversal = 1'b0;
    step();
    step();

    // Reset state
    check("rst_a_groups", 32'(a_groups), 32'h3);
    check("rst_b_groups", 32'(b_groups), 32'hF);
    check("rst_a_busy",   32'(a_busy),   32'h0);
    check("rst_a_done",   32'(a_done),   32'h0);
    check("rst_a_deg",    32'(a_deg),    32'h0);
    check("rst_a_to",     32'(a_to),     32'h0);
    rst = 1'b0;
    step();

    // Clean run: all ones, done exactly 6 cycles after start
    pulse_start();
    check("t1_busy_t1", 32'(a_busy), 32'h1);
    send(16'hFFFF); send(16'hFFFF); send(16'hFFFF); send(16'hFFFF);
    check("t1_busy_t5", 32'(a_busy), 32'h1);
    check("t1_done_t5", 32'(a_done), 32'h0);
    step();
    check("t1_done_t6",   32'(a_done),   32'h1);
    check("t1_busy_t6",   32'(a_busy),   32'h0);
    check("t1_a_groups",  32'(a_groups), 32'h3);
    check("t1_a_deg",     32'(a_deg),    32'h0);
    check("t1_b_groups",  32'(b_groups), 32'hF);

    // Lane 7 fails once: lower half lost, upper kept
    pulse_start();
    check("t2_done_clr",  32'(a_done),   32'h0);
    check("t2_busy",      32'(a_busy),   32'h1);
    check("t2_hold_mask", 32'(a_groups), 32'h3);
    send(16'hFFFF); send(16'hFFFF); send(16'hFF7F); send(16'hFFFF);
    step();
    check("t2_a_groups", 32'(a_groups), 32'h2);
    check("t2_a_deg",    32'(a_deg),    32'h1);
    check("t2_a_done",   32'(a_done),   32'h1);

    // 0F0F: four groups -> groups 0 and 2 pass, highest is 2; two halves both fail
    pulse_start();
    send(16'h0F0F); send(16'h0F0F); send(16'h0F0F); send(16'h0F0F);
    step();
    check("t3_b_groups", 32'(b_groups), 32'h4);
    check("t3_b_deg",    32'(b_deg),    32'h1);
    check("t3_a_groups", 32'(a_groups), 32'h0);
    check("t3_a_deg",    32'(a_deg),    32'h1);

    // Timeout with only two samples (TIMEOUT_CYCLES=8 instance)
    pulse_start();
    check("t4_a_deg_clr",  32'(a_deg),    32'h0);
    check("t4_a_hold",     32'(a_groups), 32'h0);
    send(16'hFFFF); send(16'hFFFF);
    repeat (5) step();
    check("t4_c_busy_c8", 32'(c_busy), 32'h1);
    check("t4_c_done_c8", 32'(c_done), 32'h0);
    step();
    check("t4_c_done",   32'(c_done),   32'h1);
    check("t4_c_to",     32'(c_to),     32'h1);
    check("t4_c_groups", 32'(c_groups), 32'h0);
    check("t4_c_deg",    32'(c_deg),    32'h1);
    check("t4_a_busy",   32'(a_busy),   32'h1);

    // Reset in the middle of dut_a's collect phase
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_a_groups", 32'(a_groups), 32'h3);
    check("t5_a_busy",   32'(a_busy),   32'h0);
    check("t5_a_done",   32'(a_done),   32'h0);
    check("t5_a_deg",    32'(a_deg),    32'h0);
    check("t5_a_to",     32'(a_to),     32'h0);
    check("t5_c_to",     32'(c_to),     32'h0);
    check("t5_b_groups", 32'(b_groups), 32'hF);

    // Fourth sample lands on the expiry cycle: sample wins
    pulse_start();
    send(16'hFFFF); send(16'hFFFF); send(16'hFFFF);
    repeat (4) step();
    send(16'hFFFF);
    check("t6_c_busy", 32'(c_busy), 32'h1);
    check("t6_c_done", 32'(c_done), 32'h0);
    check("t6_c_to",   32'(c_to),   32'h0);
    step();
    check("t6_c_done2",  32'(c_done),   32'h1);
    check("t6_c_to2",    32'(c_to),     32'h0);
    check("t6_c_groups", 32'(c_groups), 32'h3);
    check("t6_c_deg",    32'(c_deg),    32'h0);

    // Start while busy is ignored; run length unchanged; 7FFF keeps lower half only
    pulse_start();
    send(16'hFFFF);
    i_start = 1'b1;
    send(16'h7FFF);
    i_start = 1'b0;
    send(16'hFFFF); send(16'hFFFF);
    check("t7_done_t5", 32'(a_done), 32'h0);
    step();
    check("t7_done_t6",  32'(a_done),   32'h1);
    check("t7_a_groups", 32'(a_groups), 32'h1);
    check("t7_a_deg",    32'(a_deg),    32'h1);
    check("t7_b_groups", 32'(b_groups), 32'h4);

`ifdef LANE_MAP_REVERSAL_EN
    // Reversed 00FF looks like FF00: upper half passes
    i_lane_reversal = 1'b1;
    pulse_start();
    send(16'h00FF); send(16'h00FF); send(16'h00FF); send(16'h00FF);
    step();
    check("t8_rev_groups", 32'(a_groups), 32'h2);
    check("t8_rev_deg",    32'(a_deg),    32'h1);
    i_lane_reversal = 1'b0;
    pulse_start();
    send(16'h00FF); send(16'h00FF); send(16'h00FF); send(16'h00FF);
    step();
    check("t8_fwd_groups", 32'(a_groups), 32'h1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/functional_lane_mapper.md
# functional_lane_mapper

Parametrised lane-degrade decision block for the MBINIT functional-lane setup step. It collects NUM_SAMPLES per-lane pass/fail vectors from the data-to-clock training result path and ANDs them into a history. It then partitions the lanes into NUM_GROUPS equal groups and selects either full width or a single surviving group. It generalises the fixed 16-lane, two-half setup to any lane/group count and adds multi-sample accumulation, a start/busy/done handshake and a timeout.

## Interface
- NUM_LANES, 16: lanes under test. Must be a multiple of NUM_GROUPS.
- NUM_GROUPS, 2: equal-size lane groups. Must be ≥1.
- NUM_SAMPLES, 4: result vectors ANDed per run. Must be ≥1.
- TIMEOUT_CYCLES, 1024: maximum cycles spent in COLLECT. Must be ≥ NUM_SAMPLES.
- CLK  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  single-cycle run request.
- i_result_valid  in  1  qualifies i_result.
- i_result  in  NUM_LANES  per-lane pass (1) / fail (0).
- i_lane_reversal  in  1  reverse lane order before evaluation. Present only with LANE_MAP_REVERSAL_EN.
- o_busy  out  1  high in COLLECT and DECIDE.
- o_functional_groups  out  NUM_GROUPS  enabled-group mask; bit g covers lanes [g*LPG +: LPG], where LPG = NUM_LANES/NUM_GROUPS.
- o_degraded  out  1  run finished with anything other than all groups enabled.
- o_timeout  out  1  run ended by timeout.
- o_done  out  1  level; high in DONE.

## Operation
- States:
  - IDLE: i_start moves to COLLECT.
  - COLLECT: sample counter reaching NUM_SAMPLES moves to DECIDE; timer expiry moves to DONE.
  - DECIDE: always moves to DONE after one cycle.
  - DONE: i_start moves to COLLECT.
- On entry to COLLECT: accumulator set to all ones; sample counter and timer cleared; o_done, o_timeout and o_degraded cleared. o_functional_groups holds its previous value.
- COLLECT: each i_result_valid cycle does acc <= acc & i_result and increments the sample counter. The timer increments every cycle.
- DECIDE computes:
  - group_pass[g] = &acc[g*LPG +: LPG].
  - If all groups pass: mask is all ones.
  - Else if any group passes: mask is one-hot at the highest-indexed passing group.
  - Else: mask is zero.
  - o_degraded = (mask != all ones).
- With NUM_GROUPS=2 this gives 11 / 10 / 01 / 00 in priority order: all pass, upper passes, lower passes, none.
- Timeout: when the timer reaches TIMEOUT_CYCLES-1 in COLLECT without completing, go to DONE. Mask = 0, o_timeout = 1, o_degraded = 1.
- i_start while busy is ignored. i_result_valid outside COLLECT is ignored.
- Results are sticky in DONE until the next i_start or rst.

## Timing
- Reset values: o_functional_groups all ones; o_busy, o_done, o_degraded, o_timeout all 0; state IDLE.
- i_start at cycle T gives o_busy = 1 at T+1.
- Last sample accepted at cycle S:
  - DECIDE during S+1.
  - o_functional_groups, o_degraded and o_done valid at S+2; o_busy low at S+2.
- Minimum run with back-to-back valids: i_start at T gives o_done at T+NUM_SAMPLES+2.
- If the last sample and timer expiry occur in the same cycle, the sample wins and the run completes normally.
- rst mid-run: every output returns to its reset value on the next edge; accumulator and counters are discarded.
- i_start in DONE clears o_done on the next edge.

## Configuration
- LANE_MAP_REVERSAL_EN defined:
  - i_lane_reversal port exists.
  - When high, each sample is bit-reversed (lane i becomes lane NUM_LANES-1-i) before the AND.
  - The mask is reported in the reversed lane order.
- LANE_MAP_REVERSAL_EN undefined: the port is absent and samples are used as-is.

## Structure
- Package lane_map_pkg holds:
  - state enum (IDLE, COLLECT, DECIDE, DONE);
  - helper function for counter width, clog2 of max(NUM_SAMPLES, TIMEOUT_CYCLES)+1;
  - localparam rule LPG = NUM_LANES/NUM_GROUPS.
- One combinational sub-module, lane_group_selector: takes the accumulator and returns the mask and degraded flag. It is reusable by the TX-side lane map.
- Top level holds the FSM, the counters and the output registers.

## Test plan
- Defaults, 4 valid samples of 16'hFFFF → o_functional_groups = 2'b11, o_degraded = 0, o_done high exactly 6 cycles after i_start.
- Samples FFFF, FFFF, FF7F, FFFF → lower group fails → mask 2'b10, o_degraded = 1.
- NUM_LANES=16, NUM_GROUPS=4, sample 16'h0F0F repeated → groups 0 and 2 pass → mask 4'b0100.
- TIMEOUT_CYCLES=8, only 2 valid samples supplied → o_timeout = 1, mask 0, o_done at cycle 8 of COLLECT. Repeat with the 4th valid landing on the expiry cycle → normal completion, o_timeout = 0.
- rst asserted mid-COLLECT → next cycle all outputs at reset values. i_start during COLLECT → ignored, run length unchanged.
- LANE_MAP_REVERSAL_EN, i_lane_reversal = 1, samples 16'h00FF → mask 2'b10.
